// File: rtl/csr_issue.sv
// csr_issue: executes one decoded Zicsr instruction at a time against an
// external CSR array. Sequence is IDLE -> READ -> [WRITE] -> RESP, and a new
// instruction is taken only in IDLE. The read-modify-write is split so that
// the CSR array sees a plain combinational read followed by one full-word
// write strobe. All outputs toward the pipeline and the CSR array are flops.
module csr_issue #(
  parameter int REG_WIDTH = 64,
  parameter int CSR       = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           in_funct3,
  input  logic [CSR-1:0]       in_csr_addr,
  input  logic [4:0]           in_rs1_idx,
  input  logic [REG_WIDTH-1:0] in_rs1_val,
  input  logic [4:0]           in_rd,
  output logic [CSR-1:0]       csr_addr,
  input  logic [REG_WIDTH-1:0] csr_rdata,
  output logic                 csr_we,
  output logic [REG_WIDTH-1:0] csr_wdata,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4:0]           out_rd,
  output logic [REG_WIDTH-1:0] out_data,
  output logic                 out_wb_en,
  output logic                 out_illegal
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t                 state_q, state_d;
  logic [2:0]             funct3_q, funct3_d;
  logic [CSR-1:0]         addr_q, addr_d;
  logic [4:0]             rs1_idx_q, rs1_idx_d;
  logic [REG_WIDTH-1:0]   rs1_val_q, rs1_val_d;
  logic [4:0]             rd_q, rd_d;
  logic [REG_WIDTH-1:0]   wdata_q, wdata_d;
  logic                   we_q, we_d;
  logic                   in_ready_q, in_ready_d;
  logic                   out_valid_q, out_valid_d;
  logic [4:0]             out_rd_q, out_rd_d;
  logic [REG_WIDTH-1:0]   out_data_q, out_data_d;
  logic                   out_wb_en_q, out_wb_en_d;
  logic                   out_illegal_q, out_illegal_d;

  logic [REG_WIDTH-1:0]   operand;
  logic [REG_WIDTH-1:0]   new_val;
  logic                   bad_op, intent, read_only, illegal, need_write;

  // Decode of the latched instruction; only consumed while in READ.
  always_comb begin
    operand    = funct3_q[2] ? REG_WIDTH'(rs1_idx_q) : rs1_val_q;
    // Set/clear with x0 (or zimm 0) is a pure read; a nonzero index still
    // writes even when the register value happens to be zero.
    bad_op     = (funct3_q[1:0] == 2'b00);
    intent     = (funct3_q[1:0] == 2'b01) || (rs1_idx_q != 5'd0);
    read_only  = (addr_q[CSR-1 -: 2] == 2'b11);
    illegal    = bad_op || (intent && read_only);
    need_write = intent && !illegal;
    case (funct3_q[1:0])
      2'b10:   new_val = csr_rdata | operand;
      2'b11:   new_val = csr_rdata & ~operand;
      default: new_val = operand;
    endcase
  end

  // Next-state and next-output computation.
  always_comb begin
    state_d       = state_q;
    funct3_d      = funct3_q;
    addr_d        = addr_q;
    rs1_idx_d     = rs1_idx_q;
    rs1_val_d     = rs1_val_q;
    rd_d          = rd_q;
    wdata_d       = wdata_q;
    out_rd_d      = out_rd_q;
    out_data_d    = out_data_q;
    out_wb_en_d   = out_wb_en_q;
    out_illegal_d = out_illegal_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          funct3_d  = in_funct3;
          addr_d    = in_csr_addr;
          rs1_idx_d = in_rs1_idx;
          rs1_val_d = in_rs1_val;
          rd_d      = in_rd;
          state_d   = READ;
        end
      end
      READ: begin
        // Response fields are frozen here so they stay stable through RESP.
        wdata_d       = new_val;
        out_rd_d      = rd_q;
        out_data_d    = illegal ? '0 : csr_rdata;
        out_wb_en_d   = !illegal && (rd_q != 5'd0);
        out_illegal_d = illegal;
        state_d       = need_write ? WRITE : RESP;
      end
      WRITE: state_d = RESP;
      RESP: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    we_d        = (state_d == WRITE);
    out_valid_d = (state_d == RESP);
    in_ready_d  = (state_d == IDLE);
  end

  // State and registered outputs; reset also kills any in-flight write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      funct3_q      <= '0;
      addr_q        <= '0;
      rs1_idx_q     <= '0;
      rs1_val_q     <= '0;
      rd_q          <= '0;
      wdata_q       <= '0;
      we_q          <= 1'b0;
      in_ready_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      out_rd_q      <= '0;
      out_data_q    <= '0;
      out_wb_en_q   <= 1'b0;
      out_illegal_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      funct3_q      <= funct3_d;
      addr_q        <= addr_d;
      rs1_idx_q     <= rs1_idx_d;
      rs1_val_q     <= rs1_val_d;
      rd_q          <= rd_d;
      wdata_q       <= wdata_d;
      we_q          <= we_d;
      in_ready_q    <= in_ready_d;
      out_valid_q   <= out_valid_d;
      out_rd_q      <= out_rd_d;
      out_data_q    <= out_data_d;
      out_wb_en_q   <= out_wb_en_d;
      out_illegal_q <= out_illegal_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign csr_addr    = addr_q;
  assign csr_we      = we_q;
  assign csr_wdata   = wdata_q;
  assign out_valid   = out_valid_q;
  assign out_rd      = out_rd_q;
  assign out_data    = out_data_q;
  assign out_wb_en   = out_wb_en_q;
  assign out_illegal = out_illegal_q;

endmodule
